// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with valid/ready handshakes on both sides.
// Ports: clk, reset_n (async, active-low); in_valid/in_ready with
//   SrcA, SrcB, ALUControl; out_valid/out_ready with registered
//   ALUResult, Zero (ALUResult == 0) and Overflow (signed add/sub).
// Single-cycle ops finish on the input handshake edge; mul/mulhu use
// shift-add and divu/remu (B != 0) use restoring division, one bit/cycle.
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic [3:0]       ALUControl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             Overflow
);

    localparam int SW = $clog2(WIDTH);
    localparam int CW = (SW < 1) ? 1 : SW;

    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_SUB   = 4'h1;
    localparam logic [3:0] OP_AND   = 4'h2;
    localparam logic [3:0] OP_OR    = 4'h3;
    localparam logic [3:0] OP_SLL   = 4'h4;
    localparam logic [3:0] OP_SLT   = 4'h5;
    localparam logic [3:0] OP_XOR   = 4'h6;
    localparam logic [3:0] OP_SRL   = 4'h7;
    localparam logic [3:0] OP_SRA   = 4'h8;
    localparam logic [3:0] OP_SLTU  = 4'h9;
    localparam logic [3:0] OP_MUL   = 4'hA;
    localparam logic [3:0] OP_MULHU = 4'hB;
    localparam logic [3:0] OP_DIVU  = 4'hC;
    localparam logic [3:0] OP_REMU  = 4'hD;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [3:0]         r_op;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_prod;
    logic [WIDTH:0]     r_rem;
    logic [WIDTH-1:0]   r_quot;
    logic [WIDTH-1:0]   r_result;
    logic               r_zero;
    logic               r_ovf;

    // Single-cycle datapath, driven straight from the inputs in IDLE.
    logic             w_sub;
    logic [WIDTH-1:0] w_bx;
    logic [WIDTH:0]   w_sum;
    logic             w_ovf;
    logic [SW-1:0]    w_shamt;
    logic [WIDTH-1:0] w_sc_res;
    logic             w_sc_ovf;
    logic             w_is_mul;
    logic             w_is_div;
    logic             w_last;

    // sub/slt/sltu all share A + ~B + 1.
    assign w_sub   = (ALUControl == OP_SUB) || (ALUControl == OP_SLT) ||
                     (ALUControl == OP_SLTU);
    assign w_bx    = w_sub ? ~SrcB : SrcB;
    assign w_sum   = {1'b0, SrcA} + {1'b0, w_bx} +
                     {{WIDTH{1'b0}}, w_sub};
    assign w_ovf   = (SrcA[WIDTH-1] == w_bx[WIDTH-1]) &&
                     (w_sum[WIDTH-1] != SrcA[WIDTH-1]);
    assign w_shamt = SrcB[SW-1:0];

    assign w_is_mul = (ALUControl == OP_MUL) || (ALUControl == OP_MULHU);
    assign w_is_div = ((ALUControl == OP_DIVU) ||
                       (ALUControl == OP_REMU)) && (SrcB != '0);
    assign w_last   = (r_cnt == CW'(WIDTH - 1));

    always_comb begin
        w_sc_res = '0;
        w_sc_ovf = 1'b0;
        case (ALUControl)
            OP_ADD:  begin
                w_sc_res = w_sum[WIDTH-1:0];
                w_sc_ovf = w_ovf;
            end
            OP_SUB:  begin
                w_sc_res = w_sum[WIDTH-1:0];
                w_sc_ovf = w_ovf;
            end
            OP_AND:  w_sc_res = SrcA & SrcB;
            OP_OR:   w_sc_res = SrcA | SrcB;
            OP_SLL:  w_sc_res = SrcA << w_shamt;
            OP_SLT:  w_sc_res = {{(WIDTH-1){1'b0}}, w_ovf ^ w_sum[WIDTH-1]};
            OP_XOR:  w_sc_res = SrcA ^ SrcB;
            OP_SRL:  w_sc_res = SrcA >> w_shamt;
            OP_SRA:  w_sc_res = $unsigned($signed(SrcA) >>> w_shamt);
            OP_SLTU: w_sc_res = {{(WIDTH-1){1'b0}}, ~w_sum[WIDTH]};
            // Only reached here on divide by zero.
            OP_DIVU: w_sc_res = '1;
            OP_REMU: w_sc_res = SrcA;
            default: w_sc_res = '0;
        endcase
    end

    // Shift-add step: add multiplicand to the upper half when the
    // current multiplier bit (LSB) is set, then shift right by one.
    logic [WIDTH:0]     w_madd;
    logic [2*WIDTH-1:0] w_prod_nxt;

    assign w_madd     = r_prod[0] ?
                        ({1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, r_a}) :
                        {1'b0, r_prod[2*WIDTH-1:WIDTH]};
    assign w_prod_nxt = {w_madd, r_prod[WIDTH-1:1]};

    // Restoring step: bring in the next dividend bit, try subtracting.
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH:0]   w_rem_nxt;
    logic [WIDTH-1:0] w_quot_nxt;

    assign w_shift    = {r_rem[WIDTH-1:0], r_quot[WIDTH-1]};
    assign w_diff     = w_shift - {1'b0, r_b};
    assign w_rem_nxt  = w_diff[WIDTH] ? w_shift : w_diff;
    assign w_quot_nxt = {r_quot[WIDTH-2:0], ~w_diff[WIDTH]};

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    if (w_is_mul)      w_next = S_MUL;
                    else if (w_is_div) w_next = S_DIV;
                    else               w_next = S_DONE;
                end
            end
            S_MUL:   if (w_last) w_next = S_DONE;
            S_DIV:   if (w_last) w_next = S_DONE;
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_cnt    <= '0;
            r_prod   <= '0;
            r_rem    <= '0;
            r_quot   <= '0;
            r_result <= '0;
            r_zero   <= 1'b1;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a    <= SrcA;
                        r_b    <= SrcB;
                        r_op   <= ALUControl;
                        r_cnt  <= '0;
                        r_prod <= {{WIDTH{1'b0}}, SrcB};
                        r_rem  <= '0;
                        r_quot <= SrcA;
                        if (!w_is_mul && !w_is_div) begin
                            r_result <= w_sc_res;
                            r_zero   <= (w_sc_res == '0);
                            r_ovf    <= w_sc_ovf;
                        end
                    end
                end
                S_MUL: begin
                    r_prod <= w_prod_nxt;
                    r_cnt  <= r_cnt + CW'(1);
                    if (w_last) begin
                        if (r_op == OP_MUL) begin
                            r_result <= w_prod_nxt[WIDTH-1:0];
                            r_zero   <= (w_prod_nxt[WIDTH-1:0] == '0);
                        end else begin
                            r_result <= w_prod_nxt[2*WIDTH-1:WIDTH];
                            r_zero   <= (w_prod_nxt[2*WIDTH-1:WIDTH] == '0);
                        end
                        r_ovf <= 1'b0;
                    end
                end
                S_DIV: begin
                    r_rem  <= w_rem_nxt;
                    r_quot <= w_quot_nxt;
                    r_cnt  <= r_cnt + CW'(1);
                    if (w_last) begin
                        if (r_op == OP_DIVU) begin
                            r_result <= w_quot_nxt;
                            r_zero   <= (w_quot_nxt == '0);
                        end else begin
                            r_result <= w_rem_nxt[WIDTH-1:0];
                            r_zero   <= (w_rem_nxt[WIDTH-1:0] == '0);
                        end
                        r_ovf <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign ALUResult = r_result;
    assign Zero      = r_zero;
    assign Overflow  = r_ovf;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed test of seq_alu (WIDTH=32) against an
// arithmetic reference model with per-cycle handshake/latency checks.
module tb_seq_alu;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] SrcA = '0;
    logic [31:0] SrcB = '0;
    logic [3:0]  ALUControl = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] ALUResult;
    logic        Zero;
    logic        Overflow;

    int errors = 0;
    int checks = 0;

    bit          busy = 1'b0;
    int          cyc = 0;
    int          hs = 0;
    int          m_lat = 1;
    logic [31:0] m_res = '0;
    logic        m_ovf = 1'b0;
    bit          ev;

    seq_alu #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .ALUControl (ALUControl),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ALUResult  (ALUResult),
        .Zero       (Zero),
        .Overflow   (Overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference: plain arithmetic on wide integers.
    function automatic void model(input logic [3:0] op,
                                  input logic [31:0] a,
                                  input logic [31:0] b,
                                  output logic [31:0] r,
                                  output logic o,
                                  output int lat);
        longint      sa;
        longint      sb;
        longint      s;
        logic [63:0] p;
        int          sh;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        p   = {32'b0, a} * {32'b0, b};
        sh  = int'(b % 32);
        r   = '0;
        o   = 1'b0;
        lat = 1;
        case (op)
            4'h0: begin
                s = sa + sb;
                r = a + b;
                o = (s != longint'($signed(r)));
            end
            4'h1: begin
                s = sa - sb;
                r = a - b;
                o = (s != longint'($signed(r)));
            end
            4'h2: r = a & b;
            4'h3: r = a | b;
            4'h4: r = a << sh;
            4'h5: r = (sa < sb) ? 32'd1 : 32'd0;
            4'h6: r = a ^ b;
            4'h7: r = a >> sh;
            4'h8: r = $signed(a) >>> sh;
            4'h9: r = (a < b) ? 32'd1 : 32'd0;
            4'hA: begin r = p[31:0];  lat = 33; end
            4'hB: begin r = p[63:32]; lat = 33; end
            4'hC: begin
                r   = (b == 0) ? 32'hFFFF_FFFF : a / b;
                lat = (b == 0) ? 1 : 33;
            end
            4'hD: begin
                r   = (b == 0) ? a : a % b;
                lat = (b == 0) ? 1 : 33;
            end
            default: r = '0;
        endcase
    endfunction

    // Transaction-level model of the handshakes.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy = 1'b0;
            cyc  = 0;
            hs   = 0;
        end else begin
            if (busy) begin
                if ((cyc - hs >= m_lat - 1) && out_ready) busy = 1'b0;
            end else if (in_valid) begin
                model(ALUControl, SrcA, SrcB, m_res, m_ovf, m_lat);
                busy = 1'b1;
                hs   = cyc + 1;
            end
            cyc++;
        end
    end

    always @(negedge clk) begin
        if (!reset_n) begin
            chk("rst_out_valid", out_valid, 0);
            chk("rst_result", ALUResult, 0);
            chk("rst_zero", Zero, 1);
            chk("rst_ovf", Overflow, 0);
        end else begin
            ev = busy && (cyc - hs >= m_lat - 1);
            chk("in_ready", in_ready, !busy);
            chk("out_valid", out_valid, ev);
            if (ev) begin
                chk("result", ALUResult, m_res);
                chk("zero", Zero, m_res == 0);
                chk("overflow", Overflow, m_ovf);
            end
        end
    end

    task automatic run_op(input string name, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input logic eo,
                          input int elat, input int hold);
        int n;
        @(negedge clk);
        ALUControl = op;
        SrcA       = a;
        SrcB       = b;
        in_valid   = 1'b1;
        @(negedge clk);
        in_valid   = 1'b0;
        SrcA       = $urandom;
        SrcB       = $urandom;
        ALUControl = 4'($urandom);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout, no out_valid in %0d cycles",
                     name, n);
        end else begin
            chk(name, ALUResult, exp);
            chk({name, "_ovf"}, Overflow, eo);
            chk({name, "_lat"}, n + 1, elat);
        end
        repeat (hold) begin
            in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] pr;
        logic        po;
        int          pl;

        repeat (3) @(negedge clk);
        chk("reset_result", ALUResult, 32'h0);
        chk("reset_zero", Zero, 1);
        chk("reset_valid", out_valid, 0);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("reset_in_ready", in_ready, 1);

        model(4'h0, 32'h7FFF_FFFF, 32'h1, pr, po, pl);
        chk("pin_add", pr, 32'h8000_0000);
        chk("pin_add_ovf", po, 1);
        model(4'hB, 32'hFFFF_FFFF, 32'hFFFF_FFFF, pr, po, pl);
        chk("pin_mulhu", pr, 32'hFFFF_FFFE);
        chk("pin_mulhu_lat", pl, 33);
        model(4'h8, 32'h8000_0000, 32'd4, pr, po, pl);
        chk("pin_sra", pr, 32'hF800_0000);

        run_op("add_ovf", 4'h0, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1, 1, 0);
        run_op("add_wrap", 4'h0, 32'hFFFF_FFFF, 32'h1, 32'h0, 0, 1, 0);
        run_op("sub_zero", 4'h1, 32'd5, 32'd5, 32'h0, 0, 1, 0);
        run_op("sub_ovf", 4'h1, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1, 1, 0);
        run_op("slt", 4'h5, 32'hFFFF_FFFF, 32'h1, 32'h1, 0, 1, 0);
        run_op("sltu", 4'h9, 32'hFFFF_FFFF, 32'h1, 32'h0, 0, 1, 0);
        run_op("sra", 4'h8, 32'h8000_0000, 32'd4, 32'hF800_0000, 0, 1, 0);
        run_op("srl", 4'h7, 32'h8000_0000, 32'd4, 32'h0800_0000, 0, 1, 0);
        run_op("sll35", 4'h4, 32'h1, 32'd35, 32'h8, 0, 1, 0);
        run_op("and", 4'h2, 32'hF0F0_FF00, 32'hFF00_F0F0, 32'hF000_F000, 0, 1, 0);
        run_op("or", 4'h3, 32'hF0F0_FF00, 32'hFF00_F0F0, 32'hFFF0_FFF0, 0, 1, 0);
        run_op("xor", 4'h6, 32'hF0F0_FF00, 32'hFF00_F0F0, 32'h0FF0_0FF0, 0, 1, 0);
        run_op("op_e", 4'hE, 32'd5, 32'd5, 32'h0, 0, 1, 0);
        run_op("mul", 4'hA, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 0, 33, 5);
        run_op("mulhu", 4'hB, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 33, 0);
        run_op("divu", 4'hC, 32'd100, 32'd7, 32'd14, 0, 33, 5);
        run_op("remu", 4'hD, 32'd100, 32'd7, 32'd2, 0, 33, 0);
        run_op("divu0", 4'hC, 32'd5, 32'd0, 32'hFFFF_FFFF, 0, 1, 0);
        run_op("remu0", 4'hD, 32'd5, 32'd0, 32'd5, 0, 1, 0);
        run_op("sub_bp", 4'h1, 32'd9, 32'd4, 32'd5, 0, 1, 5);

        // Reset in the middle of a multiply.
        @(negedge clk);
        ALUControl = 4'hA;
        SrcA       = 32'h1234_5678;
        SrcB       = 32'h9ABC_DEF0;
        in_valid   = 1'b1;
        @(negedge clk);
        in_valid   = 1'b0;
        repeat (9) @(negedge clk);
        chk("mid_mul_busy", in_ready, 0);
        #1 reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_result", ALUResult, 32'h0);
        chk("mid_rst_zero", Zero, 1);
        @(negedge clk);
        #1 reset_n = 1'b1;
        run_op("add_after_rst", 4'h0, 32'd2, 32'd3, 32'd5, 0, 1, 0);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
